qdma_block_transfer_top: RTL and testbench
==========================================

# qdma_block_transfer_top

Single-clock DMA subsystem pairing a minimal host processor handshake FSM with a queued DMA (QDMA) block-transfer engine. The engine owns four 32-entry × 8-bit storage arrays and copies a block of words between them through an internal 8-deep FIFO. The bus handshake runs DMA_req → drq → hrq → start_transfer → dack → transfer_done. The block sits where a CPU grants bus ownership to a DMA master.

## Interface
- No parameters. Fixed sizes: FIFO depth 8; arrays 32 × 8 bit.
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, synchronous and active-low.
- DMA_req  in  1  transfer request to the processor.
- transfer_type  in  2  00 single word; 01 and 10 block of `words`; 11 reserved, treated as no-op.
- src_module, dest_module  in  3 each  0 = memory0, 1 = peripheral1, 2 = memory1, 3 = peripheral2; 4–7 invalid.
- src_address, dest_address  in  5 each  start addresses.
- words  in  5  block length, 0–31.
- drq  out  1  processor → engine request.
- hrq  out  1  engine → processor hold request.
- start_transfer  out  1  processor grant.
- dack  out  1  engine acknowledge; high while moving data.
- transfer_done  out  1  one-cycle completion pulse.
- Internal signals, named exactly: arrays memory0, memory1, peripheral1, peripheral2; registers words_to_be_transferred [4:0] and fifo_count [3:0]. Benches access these hierarchically.

## Operation
- Processor FSM:
  - P_IDLE: a rising edge of DMA_req (registered previous value, reset 0) → P_REQ.
  - P_REQ: drq=1. When hrq=1 → P_GRANT.
  - P_GRANT: start_transfer=1, drq=0. When transfer_done=1 → P_IDLE.
  - DMA_req held high produces exactly one transfer.
- Engine FSM:
  - D_IDLE: when drq=1, latch transfer_type, modules, addresses and length → D_HREQ.
  - Latched length: `words` for types 01/10, 1 for type 00, 0 for type 11.
  - If the latched length is 0 or either module is invalid, skip straight to D_DONE; no array is written.
  - D_HREQ: hrq=1. When start_transfer=1 → D_XFER.
  - D_XFER: hrq=1, dack=1. Each cycle:
    - Read: if reads remain and the FIFO is not full, read src[src_ptr], push it, src_ptr+1.
    - Write: if fifo_count>0, pop the head into dest[dest_ptr], dest_ptr+1, words_to_be_transferred−1.
    - When words_to_be_transferred reaches 0, go to D_DONE.
  - D_DONE: transfer_done=1 for one cycle, hrq=0, dack=0 → D_IDLE.
- Address pointers are 5-bit and wrap modulo 32 (31 → 0).
- Simultaneous push and pop leaves fifo_count unchanged. The FIFO never exceeds 8 entries.
- Source equal to destination is allowed. Data is copied in order.
- Transfer parameter inputs are ignored outside D_IDLE.

## Timing
- Reset (rst=0 at a clock edge):
  - Both FSMs → idle.
  - drq, hrq, start_transfer, dack, transfer_done = 0.
  - fifo_count = 0, words_to_be_transferred = 0.
  - Array contents are NOT cleared. Arrays may be preloaded before or during reset.
- Reset mid-transfer aborts immediately. Already-written destination words remain.
- All outputs are registered. Handshake latency:
  - DMA_req edge → drq +1 cycle.
  - drq → hrq +1.
  - hrq → start_transfer +1.
  - start_transfer → dack +1.
- Data path: a word read in XFER cycle k is written in cycle k+1. An N-word block occupies N+1 XFER cycles.
- transfer_done asserts the cycle after the final write. fifo_count is 0 at that point.
- Steady state holds fifo_count at 1.

## Test plan
- Block copy:
  - Setup: preload peripheral1[10..24] = 10..24; type 01, src 1 @ 10, dest 0 @ 15, words 15; pulse DMA_req high.
  - Expect: memory0[15..29] = 10..24; transfer_done pulses exactly once; drq/hrq/start_transfer/dack all back to 0.
- Single-word transfer: type 00, words 31 → exactly one word copied, other destination words unchanged.
- Wrap-around: src 30, dest 31, words 4 → dest addresses 31, 0, 1, 2 receive src[30], src[31], src[0], src[1].
- Degenerate requests: words 0, or dest_module 5 → transfer_done pulses, no array changes, dack never asserts.
- Reset mid-transfer: assert rst during D_XFER → next cycle all outputs 0, fifo_count 0; arrays retain their values.
- Held request: DMA_req high for 1000 cycles → one transfer; a new transfer starts only after DMA_req goes low then high again.

Source files
------------

// File: rtl/qdma_block_transfer_top.sv
// Host processor handshake FSM plus a queued block-transfer engine that copies
// words between four 32x8 arrays through an 8-deep FIFO.
module qdma_block_transfer_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       DMA_req,
    input  logic [1:0] transfer_type,
    input  logic [2:0] src_module,
    input  logic [2:0] dest_module,
    input  logic [4:0] src_address,
    input  logic [4:0] dest_address,
    input  logic [4:0] words,
    output logic       drq,
    output logic       hrq,
    output logic       start_transfer,
    output logic       dack,
    output logic       transfer_done
);

    typedef enum logic [1:0] {P_IDLE, P_REQ, P_GRANT} p_state_t;
    typedef enum logic [1:0] {D_IDLE, D_HREQ, D_XFER, D_DONE} d_state_t;

    localparam logic [3:0] FIFO_DEPTH = 4'd8;

    // Storage arrays; never reset so they can be preloaded around reset.
    logic [7:0] memory0     [32];
    logic [7:0] peripheral1 [32];
    logic [7:0] memory1     [32];
    logic [7:0] peripheral2 [32];

    // ---------------- processor side ----------------
    p_state_t p_state_q, p_state_d;
    logic     dma_req_prev_q;
    logic     drq_q, drq_d;
    logic     start_q, start_d;

    // ---------------- engine side -------------------
    d_state_t   e_state_q, e_state_d;
    logic [1:0] src_mod_q, src_mod_d;
    logic [1:0] dst_mod_q, dst_mod_d;
    logic [4:0] src_ptr_q, src_ptr_d;
    logic [4:0] dst_ptr_q, dst_ptr_d;
    logic [4:0] reads_left_q, reads_left_d;
    logic [4:0] words_to_be_transferred, words_to_be_transferred_d;
    logic [3:0] fifo_count, fifo_count_d;
    logic [2:0] fifo_wr_q, fifo_wr_d;
    logic [2:0] fifo_rd_q, fifo_rd_d;
    logic [7:0] fifo_mem [8];
    logic       hrq_q, hrq_d;
    logic       dack_q, dack_d;
    logic       done_q, done_d;

    logic [4:0] req_len;
    logic       req_valid;
    logic       push, pop;
    logic [7:0] src_rd_data;
    logic [7:0] fifo_head;

    assign drq            = drq_q;
    assign start_transfer = start_q;
    assign hrq            = hrq_q;
    assign dack           = dack_q;
    assign transfer_done  = done_q;

    // ================= processor FSM =================
    always_ff @(posedge clk) begin
        if (!rst) begin
            p_state_q      <= P_IDLE;
            dma_req_prev_q <= 1'b0;
            drq_q          <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            p_state_q      <= p_state_d;
            dma_req_prev_q <= DMA_req;
            drq_q          <= drq_d;
            start_q        <= start_d;
        end
    end

    // A degenerate request finishes without ever raising hrq, so P_REQ also
    // watches transfer_done to avoid re-requesting forever.
    always_comb begin
        p_state_d = p_state_q;
        case (p_state_q)
            P_IDLE:  if (DMA_req && !dma_req_prev_q) p_state_d = P_REQ;
            P_REQ: begin
                if (done_q)     p_state_d = P_IDLE;
                else if (hrq_q) p_state_d = P_GRANT;
            end
            P_GRANT: if (done_q) p_state_d = P_IDLE;
            default: p_state_d = P_IDLE;
        endcase
    end

    always_comb begin
        drq_d   = (p_state_d == P_REQ);
        start_d = (p_state_d == P_GRANT);
    end

    // ================= engine request decode =================
    always_comb begin
        case (transfer_type)
            2'b00:   req_len = 5'd1;
            2'b11:   req_len = 5'd0;
            default: req_len = words;
        endcase
        req_valid = (req_len != 5'd0) && !src_module[2] && !dest_module[2];
    end

    assign push = (e_state_q == D_XFER) && (reads_left_q != 5'd0) && (fifo_count != FIFO_DEPTH);
    assign pop  = (e_state_q == D_XFER) && (fifo_count != 4'd0);

    always_comb begin
        case (src_mod_q)
            2'd0:    src_rd_data = memory0[src_ptr_q];
            2'd1:    src_rd_data = peripheral1[src_ptr_q];
            2'd2:    src_rd_data = memory1[src_ptr_q];
            default: src_rd_data = peripheral2[src_ptr_q];
        endcase
        fifo_head = fifo_mem[fifo_rd_q];
    end

    // ================= engine FSM =================
    always_ff @(posedge clk) begin
        if (!rst) begin
            e_state_q               <= D_IDLE;
            src_mod_q               <= 2'd0;
            dst_mod_q               <= 2'd0;
            src_ptr_q               <= 5'd0;
            dst_ptr_q               <= 5'd0;
            reads_left_q            <= 5'd0;
            words_to_be_transferred <= 5'd0;
            fifo_count              <= 4'd0;
            fifo_wr_q               <= 3'd0;
            fifo_rd_q               <= 3'd0;
            hrq_q                   <= 1'b0;
            dack_q                  <= 1'b0;
            done_q                  <= 1'b0;
        end else begin
            e_state_q               <= e_state_d;
            src_mod_q               <= src_mod_d;
            dst_mod_q               <= dst_mod_d;
            src_ptr_q               <= src_ptr_d;
            dst_ptr_q               <= dst_ptr_d;
            reads_left_q            <= reads_left_d;
            words_to_be_transferred <= words_to_be_transferred_d;
            fifo_count              <= fifo_count_d;
            fifo_wr_q               <= fifo_wr_d;
            fifo_rd_q               <= fifo_rd_d;
            hrq_q                   <= hrq_d;
            dack_q                  <= dack_d;
            done_q                  <= done_d;
        end
    end

    // Datapath next-state: request latch, pointers, counters, FIFO occupancy.
    always_comb begin
        src_mod_d                 = src_mod_q;
        dst_mod_d                 = dst_mod_q;
        src_ptr_d                 = src_ptr_q;
        dst_ptr_d                 = dst_ptr_q;
        reads_left_d              = reads_left_q;
        words_to_be_transferred_d = words_to_be_transferred;
        fifo_wr_d                 = fifo_wr_q;
        fifo_rd_d                 = fifo_rd_q;
        fifo_count_d              = fifo_count;

        if (e_state_q == D_IDLE && drq_q) begin
            src_mod_d = src_module[1:0];
            dst_mod_d = dest_module[1:0];
            src_ptr_d = src_address;
            dst_ptr_d = dest_address;
            if (req_valid) begin
                reads_left_d              = req_len;
                words_to_be_transferred_d = req_len;
            end else begin
                reads_left_d              = 5'd0;
                words_to_be_transferred_d = 5'd0;
            end
        end

        if (push) begin
            src_ptr_d    = src_ptr_q + 5'd1;
            reads_left_d = reads_left_q - 5'd1;
            fifo_wr_d    = fifo_wr_q + 3'd1;
        end
        if (pop) begin
            dst_ptr_d                 = dst_ptr_q + 5'd1;
            words_to_be_transferred_d = words_to_be_transferred - 5'd1;
            fifo_rd_d                 = fifo_rd_q + 3'd1;
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count + 4'd1;
            2'b01:   fifo_count_d = fifo_count - 4'd1;
            default: fifo_count_d = fifo_count;
        endcase
    end

    always_comb begin
        e_state_d = e_state_q;
        case (e_state_q)
            D_IDLE: begin
                if (drq_q) e_state_d = req_valid ? D_HREQ : D_DONE;
            end
            D_HREQ: if (start_q) e_state_d = D_XFER;
            D_XFER: if (words_to_be_transferred_d == 5'd0) e_state_d = D_DONE;
            default: e_state_d = D_IDLE;
        endcase
    end

    always_comb begin
        hrq_d  = (e_state_d == D_HREQ) || (e_state_d == D_XFER);
        dack_d = (e_state_d == D_XFER);
        done_d = (e_state_d == D_DONE);
    end

    // ================= storage =================
    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wr_q] <= src_rd_data;
    end

    // Writes are gated by reset so an aborted transfer stops immediately.
    always_ff @(posedge clk) begin
        if (rst && pop) begin
            case (dst_mod_q)
                2'd0:    memory0[dst_ptr_q]     <= fifo_head;
                2'd1:    peripheral1[dst_ptr_q] <= fifo_head;
                2'd2:    memory1[dst_ptr_q]     <= fifo_head;
                default: peripheral2[dst_ptr_q] <= fifo_head;
            endcase
        end
    end

endmodule

// File: tb/tb_qdma_block_transfer_top.sv
// Directed plus randomized bench for qdma_block_transfer_top with an
// array-level copy model.
module tb_qdma_block_transfer_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       DMA_req;
    logic [1:0] transfer_type;
    logic [2:0] src_module, dest_module;
    logic [4:0] src_address, dest_address, words;
    logic       drq, hrq, start_transfer, dack, transfer_done;

    always #5 clk = ~clk;

    qdma_block_transfer_top dut (
        .clk            (clk),
        .rst            (rst),
        .DMA_req        (DMA_req),
        .transfer_type  (transfer_type),
        .src_module     (src_module),
        .dest_module    (dest_module),
        .src_address    (src_address),
        .dest_address   (dest_address),
        .words          (words),
        .drq            (drq),
        .hrq            (hrq),
        .start_transfer (start_transfer),
        .dack           (dack),
        .transfer_done  (transfer_done)
    );

    logic [7:0] ref_mem [4][32];
    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;
    int dack_total = 0;
    int fifo_hi_total = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (transfer_done) done_total++;
            if (dack) dack_total++;
            if (dut.fifo_count > 4'd1) fifo_hi_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] peek(input int m, input int a);
        case (m)
            0:       return dut.memory0[a];
            1:       return dut.peripheral1[a];
            2:       return dut.memory1[a];
            default: return dut.peripheral2[a];
        endcase
    endfunction

    task automatic poke(input int m, input int a, input logic [7:0] v);
        case (m)
            0:       dut.memory0[a] = v;
            1:       dut.peripheral1[a] = v;
            2:       dut.memory1[a] = v;
            default: dut.peripheral2[a] = v;
        endcase
        ref_mem[m][a] = v;
    endtask

    // Step k reads source word k (if any) and writes the word read at step k-1;
    // within a step the read sees the array before that step's write.
    task automatic model(input int sm, input int dm, input int sa, input int da,
                         input int len, input int steps);
        logic [7:0] rd [32];
        for (int k = 0; k < steps; k++) begin
            if (k < len) rd[k] = ref_mem[sm][(sa + k) % 32];
            if (k > 0)   ref_mem[dm][(da + k - 1) % 32] = rd[k - 1];
        end
    endtask

    task automatic check_arrays(input string tag);
        int bad;
        for (int m = 0; m < 4; m++) begin
            bad = 0;
            for (int a = 0; a < 32; a++)
                if (peek(m, a) !== ref_mem[m][a]) bad++;
            check($sformatf("%s_arr%0d_bad_words", tag, m), bad, 0);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {27'd0, drq, hrq, start_transfer, dack, transfer_done}, 0);
    endtask

    task automatic scramble_inputs();
        transfer_type = 2'($urandom);
        src_module    = 3'($urandom);
        dest_module   = 3'($urandom);
        src_address   = 5'($urandom);
        dest_address  = 5'($urandom);
        words         = 5'($urandom);
    endtask

    task automatic run_xfer(input string tag, input logic [1:0] t, input logic [2:0] sm,
                            input logic [2:0] dm, input logic [4:0] sa, input logic [4:0] da,
                            input logic [4:0] w, input int hold);
        int len, d0, k0, cyc;
        bit degen;
        len   = (t == 2'b00) ? 1 : (t == 2'b11) ? 0 : int'(w);
        degen = (len == 0) || (sm > 3) || (dm > 3);
        d0 = done_total;
        k0 = dack_total;
        transfer_type = t; src_module = sm; dest_module = dm;
        src_address = sa; dest_address = da; words = w;
        DMA_req = 1'b1;
        @(negedge clk);
        check({tag, "_drq_lat"}, drq, 1);
        if (degen) begin
            @(negedge clk);
            check({tag, "_done_lat"}, transfer_done, 1);
            scramble_inputs();
        end else begin
            @(negedge clk);
            check({tag, "_hrq_lat"}, hrq, 1);
            scramble_inputs();
            @(negedge clk);
            check({tag, "_start_lat"}, start_transfer, 1);
            @(negedge clk);
            check({tag, "_dack_lat"}, dack, 1);
            @(negedge clk);
            check({tag, "_fifo_steady"}, dut.fifo_count, 1);
            cyc = 0;
            while (!transfer_done && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check({tag, "_done_seen"}, transfer_done, 1);
            check({tag, "_fifo_at_done"}, dut.fifo_count, 0);
            model(int'(sm), int'(dm), int'(sa), int'(da), len, len + 1);
        end
        repeat (hold) @(negedge clk);
        DMA_req = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_total - d0, 1);
        check({tag, "_dack_cycles"}, dack_total - k0, degen ? 0 : len + 1);
        check_idle({tag, "_idle_after"});
        check_arrays(tag);
        $display("xfer %s: type=%0d src=%0d@%0d dst=%0d@%0d words=%0d len=%0d degen=%0d",
                 tag, t, sm, sa, dm, da, w, len, degen);
    endtask

    initial begin
        int bad, cyc;
        rst = 1'b0;
        DMA_req = 1'b0;
        transfer_type = 2'd0; src_module = 3'd0; dest_module = 3'd0;
        src_address = 5'd0; dest_address = 5'd0; words = 5'd0;
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 32; a++)
                poke(m, a, 8'($urandom));
        repeat (3) @(negedge clk);
        check_idle("reset_outputs");
        check("reset_fifo_count", dut.fifo_count, 0);
        check("reset_words_left", dut.words_to_be_transferred, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("post_reset_idle");

        // Block copy peripheral1[10..24] -> memory0[15..29]
        for (int i = 10; i <= 24; i++) poke(1, i, 8'(i));
        run_xfer("block", 2'b01, 3'd1, 3'd0, 5'd10, 5'd15, 5'd15, 0);
        bad = 0;
        for (int i = 0; i < 15; i++)
            if (dut.memory0[15 + i] !== 8'(10 + i)) bad++;
        check("block_literal_values", bad, 0);

        run_xfer("single", 2'b00, 3'd2, 3'd3, 5'd7, 5'd20, 5'd31, 0);
        run_xfer("wrap", 2'b10, 3'd2, 3'd3, 5'd30, 5'd31, 5'd4, 0);
        check("wrap_dst0_from_src31", peek(3, 0), peek(2, 31));
        run_xfer("zero_words", 2'b01, 3'd0, 3'd1, 5'd3, 5'd4, 5'd0, 0);
        run_xfer("bad_dest", 2'b01, 3'd0, 3'd5, 5'd3, 5'd4, 5'd9, 0);
        run_xfer("type_11", 2'b11, 3'd0, 3'd1, 5'd3, 5'd4, 5'd9, 0);
        run_xfer("overlap", 2'b01, 3'd2, 3'd2, 5'd4, 5'd6, 5'd10, 0);
        run_xfer("full_len", 2'b10, 3'd3, 3'd1, 5'd5, 5'd9, 5'd31, 0);

        for (int n = 0; n < 20; n++) begin
            logic [2:0] sm, dm;
            sm = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            dm = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            run_xfer($sformatf("rand%0d", n), 2'($urandom), sm, dm,
                     5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 3));
        end

        // Held request: one transfer only, then a fresh edge starts another
        run_xfer("held", 2'b01, 3'd0, 3'd2, 5'd3, 5'd12, 5'd9, 1000);
        run_xfer("after_held", 2'b10, 3'd2, 3'd0, 5'd12, 5'd0, 5'd9, 0);

        // Reset in the middle of a transfer
        transfer_type = 2'b01; src_module = 3'd3; dest_module = 3'd0;
        src_address = 5'd0; dest_address = 5'd5; words = 5'd20;
        DMA_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!dack && cyc < 10);
        check("abort_dack_seen", dack, 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        DMA_req = 1'b0;
        @(negedge clk);
        check_idle("abort_outputs");
        check("abort_fifo_count", dut.fifo_count, 0);
        check("abort_words_left", dut.words_to_be_transferred, 0);
        model(3, 0, 0, 5, 20, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_arrays("abort");
        $display("xfer abort: reset after 5 transfer cycles, 4 words kept");
        run_xfer("post_abort", 2'b01, 3'd1, 3'd2, 5'd1, 5'd2, 5'd6, 0);

        check("fifo_never_above_one", fifo_hi_total, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
